encode_instruction_writer: RTL

- Assembles instruction words from field inputs: opcode, reg_dest, reg_src, and either a small or a big immediate.
- Packs each word in the exact layout the core decoder unpacks, and writes it into instruction memory at sequentially incrementing addresses.
- Sits between the program loader (host/test interface) and the instruction memory write port.
- Loads one program per start pulse and reports done or overflow.

---
 rtl/encode_instruction_writer_pkg.sv | 35 +++
 rtl/encode_instruction_writer_pack.sv | 20 ++
 rtl/encode_instruction_writer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/encode_instruction_writer_pkg.sv
// Shared instruction-format constants, opcode values and the field bundle type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encode_instruction_writer_pkg;

  // Instruction format, shared with the core decoder.
  // WORD_SIZE == OPCODE_SIZE + 2*REG_ADDR_SIZE + SMALL_IMM_SIZE
  // BIG_IMM_SIZE == REG_ADDR_SIZE + SMALL_IMM_SIZE
  localparam int WORD_SIZE      = 16;
  localparam int OPCODE_SIZE    = 4;
  localparam int REG_ADDR_SIZE  = 3;
  localparam int SMALL_IMM_SIZE = 6;
  localparam int BIG_IMM_SIZE   = 9;
  localparam int MEM_ADDR_SIZE  = 8;

  // Opcodes the decoder knows about. The writer never checks these; any
  // 4-bit value passes straight through into the packed word.
  localparam logic [OPCODE_SIZE-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'h1;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'h2;
  localparam logic [OPCODE_SIZE-1:0] OP_LOAD = 4'h5;
  localparam logic [OPCODE_SIZE-1:0] OP_LI   = 4'hC;
  localparam logic [OPCODE_SIZE-1:0] OP_JMP  = 4'hE;

  // One instruction's worth of fields as handed over by the loader.
  typedef struct packed {
    logic [OPCODE_SIZE-1:0]    opcode;
    logic [REG_ADDR_SIZE-1:0]  reg_dest;
    logic [REG_ADDR_SIZE-1:0]  reg_src;
    logic [SMALL_IMM_SIZE-1:0] small_imm;
    logic [BIG_IMM_SIZE-1:0]   big_imm;
    logic                      use_big;
  } instr_fields_t;

endpackage

// File: rtl/encode_instruction_writer_pack.sv
// Packs an instruction field bundle into the word layout the core decoder unpacks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module pack_instruction
  import encode_instruction_writer_pkg::*;
(
  input  instr_fields_t          fields,
  output logic [WORD_SIZE-1:0]   word
);

  // Big-immediate form reuses the reg_src + small_imm bit positions.
  always_comb begin
    if (fields.use_big) begin
      word = {fields.opcode, fields.reg_dest, fields.big_imm};
    end else begin
      word = {fields.opcode, fields.reg_dest, fields.reg_src, fields.small_imm};
    end
  end

endmodule

// File: rtl/encode_instruction_writer.sv
// Loads one program per start pulse: packs field bundles and writes them to sequential imem addresses.
// Latency: one cycle from bundle handshake to the registered mem_we/mem_addr/mem_wdata pulse.
// Backpressure: in_ready high only in LOAD with no address wrap pending; one bundle per cycle.
module encode_instruction_writer
  import encode_instruction_writer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [MEM_ADDR_SIZE-1:0]   base_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPCODE_SIZE-1:0]     in_opcode,
  input  logic [REG_ADDR_SIZE-1:0]   in_reg_dest,
  input  logic [REG_ADDR_SIZE-1:0]   in_reg_src,
  input  logic [SMALL_IMM_SIZE-1:0]  in_small_imm,
  input  logic [BIG_IMM_SIZE-1:0]    in_big_imm,
  input  logic                       in_use_big,
  input  logic                       in_last,
  output logic                       mem_we,
  output logic [MEM_ADDR_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [MEM_ADDR_SIZE:0]     count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_ADDR_SIZE:0]   count_q, count_d;
  logic                     ovf_pend_q, ovf_pend_d;
  logic                     overflow_q, overflow_d;
  logic                     mem_we_q, mem_we_d;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]     mem_wdata_q, mem_wdata_d;

  instr_fields_t            fields;
  logic [WORD_SIZE-1:0]     packed_word;
  logic                     handshake;
  logic                     at_top;

  assign fields = '{
    opcode:    in_opcode,
    reg_dest:  in_reg_dest,
    reg_src:   in_reg_src,
    small_imm: in_small_imm,
    big_imm:   in_big_imm,
    use_big:   in_use_big
  };

  pack_instruction u_pack (
    .fields (fields),
    .word   (packed_word)
  );

  // Once the top address has been written without a last marker, stop
  // accepting so nothing wraps onto address 0.
  assign in_ready  = (state_q == ST_LOAD) && !ovf_pend_q;
  assign handshake = in_valid && in_ready;
  assign at_top    = &wr_ptr_q;

  // Next-state, write-pointer and registered write-port computation.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ovf_pend_d  = ovf_pend_q;
    overflow_d  = overflow_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = base_addr;
          count_d    = '0;
          ovf_pend_d = 1'b0;
          overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ovf_pend_q) begin
          // The top-address write has already been emitted; finish with overflow.
          state_d    = ST_DONE;
          ovf_pend_d = 1'b0;
          overflow_d = 1'b1;
        end else if (handshake) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = packed_word;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          count_d     = count_q + 1'b1;
          if (in_last) begin
            state_d = ST_FLUSH;
          end else if (at_top) begin
            ovf_pend_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // The final write is on the port this cycle.
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any load in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_pend_q  <= 1'b0;
      overflow_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_pend_q  <= ovf_pend_d;
      overflow_q  <= overflow_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;

endmodule
